// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-side driver for a 16-bit ALU.
// Accepts one operation per valid/ready handshake and drives operand/opcode
// registers into the ALU. Those registers are held while the ALU latches its
// flags, then the accumulator/carry/zero are captured and returned over a
// result valid/ready handshake. Chaining reuses the last captured result as A.
//
// Ports:
//   iClock, iReset                        clock, async active-high reset
//   iCmdValid/oCmdReady                   command handshake
//   iCmdOpcode, iCmdA, iCmdB, iCmdChain   command fields
//   oAluA, oAluB, oAluOpcode              registered ALU inputs
//   iAluAccumulator, iAluCarry, iAluZero  ALU outputs/flags
//   oResultValid/iResultReady             result handshake
//   oResult, oCarry, oZero                captured result and flags
//   oOpCount                              completed hand-offs (wraps)
module alu_op_sequencer #(
  parameter int unsigned     WIDTH  = 16,
  parameter int unsigned     OPW    = 3,
  parameter int unsigned     CNT_W  = 8,
  parameter logic [OPW-1:0]  RST_OP = '0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iCmdValid,
  output logic             oCmdReady,
  input  logic [OPW-1:0]   iCmdOpcode,
  input  logic [WIDTH-1:0] iCmdA,
  input  logic [WIDTH-1:0] iCmdB,
  input  logic             iCmdChain,
  output logic [WIDTH-1:0] oAluA,
  output logic [WIDTH-1:0] oAluB,
  output logic [OPW-1:0]   oAluOpcode,
  input  logic [WIDTH-1:0] iAluAccumulator,
  input  logic             iAluCarry,
  input  logic             iAluZero,
  output logic             oResultValid,
  input  logic             iResultReady,
  output logic [WIDTH-1:0] oResult,
  output logic             oCarry,
  output logic             oZero,
  output logic [CNT_W-1:0] oOpCount
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] last_result;

  // Sequencer FSM with all outputs registered.
  // oAlu* are only written on command acceptance, so they hold their last
  // issued values in every other state (keeps the ALU carry intact between
  // chained arithmetic commands).
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      oCmdReady    <= 1'b1;
      oResultValid <= 1'b0;
      oAluA        <= '0;
      oAluB        <= '0;
      oAluOpcode   <= RST_OP;
      oResult      <= '0;
      oCarry       <= 1'b0;
      oZero        <= 1'b0;
      oOpCount     <= '0;
      last_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iCmdValid && oCmdReady) begin
            oAluA      <= iCmdChain ? last_result : iCmdA;
            oAluB      <= iCmdB;
            oAluOpcode <= iCmdOpcode;
            oCmdReady  <= 1'b0;
            state      <= ISSUE;
          end
        end
        // ALU latches its flags on the closing edge of this cycle.
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          oResult      <= iAluAccumulator;
          last_result  <= iAluAccumulator;
          oCarry       <= iAluCarry;
          oZero        <= iAluZero;
          oResultValid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (iResultReady) begin
            oResultValid <= 1'b0;
            oOpCount     <= oOpCount + CNT_W'(1);
            oCmdReady    <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          oCmdReady    <= 1'b1;
          oResultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed steps plus random
// operations, with a registered ALU model and an abstract expected-result model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_chain;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_acc;
  logic        alu_carry;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic [7:0]  op_count;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;
  int handoffs = 0;
  logic [15:0] last_res = 16'h0000;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(16), .OPW(3), .CNT_W(8), .RST_OP(3'b000)) dut (
    .iClock(clk), .iReset(rst),
    .iCmdValid(cmd_valid), .oCmdReady(cmd_ready),
    .iCmdOpcode(cmd_opcode), .iCmdA(cmd_a), .iCmdB(cmd_b), .iCmdChain(cmd_chain),
    .oAluA(alu_a), .oAluB(alu_b), .oAluOpcode(alu_opcode),
    .iAluAccumulator(alu_acc), .iAluCarry(alu_carry), .iAluZero(alu_zero),
    .oResultValid(res_valid), .iResultReady(res_ready),
    .oResult(result), .oCarry(carry), .oZero(zero), .oOpCount(op_count)
  );

  // ALU behaviour: returns {carry, zero, result}.
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    case (op)
      3'b000:  s = {1'b0, a & b};
      3'b001:  s = {1'b0, a | b};
      3'b010:  s = {1'b0, a ^ b};
      3'b011:  s = {1'b0, ~a};
      3'b100:  s = {1'b0, a};
      3'b101:  s = {1'b0, a} + {1'b0, b};
      3'b110:  s = {1'b0, a} - {1'b0, b};
      default: s = {1'b0, a} + 17'd1;
    endcase
    return {s[16], (s[15:0] == 16'h0000), s[15:0]};
  endfunction

  // Registered ALU model: flags and accumulator update every clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_acc <= 16'h0000; alu_carry <= 1'b0; alu_zero <= 1'b0;
    end else begin
      {alu_carry, alu_zero, alu_acc} <= alu_f(alu_opcode, alu_a, alu_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    cmd_a      = 16'($urandom);
    cmd_b      = 16'($urandom);
    cmd_opcode = 3'($urandom);
    cmd_chain  = 1'($urandom);
  endtask

  // One complete operation; hold = cycles the consumer stalls before accepting.
  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic chain, input int hold);
    logic [15:0] ea;
    logic [17:0] r;
    ea = chain ? last_res : a;
    r  = alu_f(op, ea, b);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_res_valid", 32'(res_valid), 32'd0);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    tick();                                   // accept edge N
    cmd_valid = 1'b0; scramble(); res_ready = 1'($urandom);
    check("issue_alu_a", 32'(alu_a), 32'(ea));
    check("issue_alu_b", 32'(alu_b), 32'(b));
    check("issue_alu_op", 32'(alu_opcode), 32'(op));
    check("issue_cmd_ready", 32'(cmd_ready), 32'd0);
    check("issue_res_valid", 32'(res_valid), 32'd0);
    tick();                                   // edge N+1
    scramble();
    check("capture_alu_a", 32'(alu_a), 32'(ea));
    check("capture_alu_b", 32'(alu_b), 32'(b));
    check("capture_res_valid", 32'(res_valid), 32'd0);
    tick();                                   // edge N+2: result valid
    res_ready = 1'b0;
    check("done_res_valid", 32'(res_valid), 32'd1);
    check("done_result", 32'(result), 32'(r[15:0]));
    check("done_carry", 32'(carry), 32'(r[17]));
    check("done_zero", 32'(zero), 32'(r[16]));
    check("done_cmd_ready", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; scramble();
      tick();
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_result", 32'({carry, zero, result}), 32'(r));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_alu_a", 32'(alu_a), 32'(ea));
    end
    res_ready = 1'b1;
    tick();                                   // handshake edge
    res_ready = 1'b0; cmd_valid = 1'b0;
    exp_count = (exp_count + 1) % 256;
    handoffs++;
    last_res = r[15:0];
    check("post_res_valid", 32'(res_valid), 32'd0);
    check("post_op_count", 32'(op_count), 32'(exp_count));
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_alu_op_kept", 32'(alu_opcode), 32'(op));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_alu"}, 32'({alu_opcode, alu_a}), 32'd0);
    check({tag, "_alu_b"}, 32'(alu_b), 32'd0);
    check({tag, "_result"}, 32'({carry, zero, result}), 32'd0);
    check({tag, "_op_count"}, 32'(op_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_opcode = 3'b000; cmd_a = 16'h0000; cmd_b = 16'h0000; cmd_chain = 1'b0;
    #1;
    check_reset_vals("por");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic add: 3 + 4.
    do_op(3'b101, 16'h0003, 16'h0004, 1'b0, 0);
    check("add_result", 32'(result), 32'h0007);

    // Reset asserted while in CAPTURE discards the operation.
    cmd_valid = 1'b1; cmd_opcode = 3'b101; cmd_a = 16'h1234; cmd_b = 16'h1111; cmd_chain = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    exp_count = 0; handoffs = 0; last_res = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_reset_no_valid", 32'(res_valid), 32'd0);
      check("mid_reset_count", 32'(op_count), 32'd0);
    end

    // Chain with no prior result uses zero as A.
    do_op(3'b100, 16'hBEEF, 16'h5555, 1'b1, 0);
    check("chain_from_reset", 32'(result), 32'h0000);

    // Consumer stall.
    do_op(3'b101, 16'h0003, 16'h0004, 1'b0, 5);

    // Overflow with carry/zero, then chained add.
    do_op(3'b101, 16'hFFFF, 16'h0001, 1'b0, 1);
    check("ovf_flags", 32'({carry, zero}), 32'b11);
    do_op(3'b101, 16'hAAAA, 16'h0001, 1'b1, 0);
    check("chain_result", 32'(result), 32'h0001);

    // Random operations until the counter wraps.
    while (handoffs < 256) begin
      do_op(3'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 2)));
    end
    check("count_wrap", 32'(op_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
